// File: rtl/vx_writeback_arb.sv
`default_nettype none
// ============================================================================
// Module   : vx_writeback_arb
// Purpose  : Round-robin writeback arbiter over execution-unit result streams,
//            packet-locked until eop, with registered writeback and retire count.
// Revision : 1.0 - initial release
// ============================================================================
module vx_writeback_arb #(
    parameter int NUM_UNITS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 6,
    parameter int UUID_WIDTH  = 44,
    parameter int PC_WIDTH    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_UNITS-1:0]              unit_valid,
    output logic [NUM_UNITS-1:0]              unit_ready,
    input  logic [NUM_UNITS*UUID_WIDTH-1:0]   unit_uuid,
    input  logic [NUM_UNITS*NW_BITS-1:0]      unit_wid,
    input  logic [NUM_UNITS*PC_WIDTH-1:0]     unit_PC,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]  unit_tmask,
    input  logic [NUM_UNITS-1:0]              unit_wb,
    input  logic [NUM_UNITS*NR_BITS-1:0]      unit_rd,
    input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] unit_data,
    input  logic [NUM_UNITS-1:0]              unit_eop,
    output logic                              wb_valid,
    output logic [UUID_WIDTH-1:0]             wb_uuid,
    output logic [NW_BITS-1:0]                wb_wid,
    output logic [PC_WIDTH-1:0]               wb_PC,
    output logic [NUM_THREADS-1:0]            wb_tmask,
    output logic [NR_BITS-1:0]                wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]       wb_data,
    output logic                              wb_eop,
    output logic                              commit_valid,
    output logic [NW_BITS-1:0]                commit_wid,
    output logic [63:0]                       instret
);

    localparam int IDX_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DATA_W = NUM_THREADS * XLEN;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             lock;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] next_ptr;

    // Scan downward so the last hit written is the lowest offset from rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (lock) begin
            grant_valid = unit_valid[lock_idx];
            grant_idx   = lock_idx;
        end else begin
            for (int off = NUM_UNITS - 1; off >= 0; off--) begin
                cand = IDX_W'((int'(rr_ptr) + off) % NUM_UNITS);
                if (unit_valid[cand]) begin
                    grant_valid = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    always_comb begin
        unit_ready = '0;
        if (grant_valid && !reset) begin
            unit_ready[grant_idx] = 1'b1;
        end
    end

    assign next_ptr = IDX_W'((int'(grant_idx) + 1) % NUM_UNITS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr       <= '0;
            lock         <= 1'b0;
            lock_idx     <= '0;
            wb_valid     <= 1'b0;
            wb_uuid      <= '0;
            wb_wid       <= '0;
            wb_PC        <= '0;
            wb_tmask     <= '0;
            wb_rd        <= '0;
            wb_data      <= '0;
            wb_eop       <= 1'b0;
            commit_valid <= 1'b0;
            commit_wid   <= '0;
            instret      <= '0;
        end else begin
            wb_valid     <= 1'b0;
            commit_valid <= 1'b0;
            if (grant_valid) begin
                wb_valid <= unit_wb[grant_idx];
                wb_uuid  <= unit_uuid[grant_idx*UUID_WIDTH +: UUID_WIDTH];
                wb_wid   <= unit_wid[grant_idx*NW_BITS +: NW_BITS];
                wb_PC    <= unit_PC[grant_idx*PC_WIDTH +: PC_WIDTH];
                wb_tmask <= unit_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
                wb_rd    <= unit_rd[grant_idx*NR_BITS +: NR_BITS];
                wb_data  <= unit_data[grant_idx*DATA_W +: DATA_W];
                wb_eop   <= unit_eop[grant_idx];
                if (unit_eop[grant_idx]) begin
                    lock         <= 1'b0;
                    rr_ptr       <= next_ptr;
                    instret      <= instret + 64'd1;
                    commit_valid <= 1'b1;
                    commit_wid   <= unit_wid[grant_idx*NW_BITS +: NW_BITS];
                end else begin
                    lock     <= 1'b1;
                    lock_idx <= grant_idx;
                end
            end
        end
    end

endmodule
`default_nettype wire
